// File: rtl/mul_tbl_pkg.sv
// Shared types and constants for the table-based 8x8 multiplier sequencer.
// Holds the FSM state type, datapath widths and the per-issue nibble/shift tables.
package mul_tbl_pkg;

  localparam int NIB_W  = 4;
  localparam int TBL_W  = 8;
  localparam int OPND_W = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Per issue index k: use the high nibble of x / y, and the partial-product shift.
  localparam logic             X_HI  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic             Y_HI  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [NIB_W-1:0] SHIFT [4] = '{4'd0, 4'd4, 4'd4, 4'd8};

  function automatic logic [NIB_W-1:0] nib_sel(input logic [OPND_W-1:0] op, input logic hi);
    logic [NIB_W-1:0] nib;
    if (hi) begin
      nib = op[OPND_W-1:NIB_W];
    end else begin
      nib = op[NIB_W-1:0];
    end
    return nib;
  endfunction

endpackage

// File: rtl/tbl_lat_pipe.sv
// Delay line that tracks {valid, shift} of each table lookup across the table latency.
// DEPTH=0 is a pure pass-through for a combinational table.
module tbl_lat_pipe
  import mul_tbl_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             in_vld,
  input  logic [NIB_W-1:0] in_shift,
  output logic             out_vld,
  output logic [NIB_W-1:0] out_shift
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign out_vld   = in_vld;
      assign out_shift = in_shift;
    end else begin : g_dly
      logic             vld_r   [DEPTH];
      logic [NIB_W-1:0] shift_r [DEPTH];

      // Shift register stage chain, cleared synchronously so aborted lookups vanish.
      always_ff @(posedge clk) begin
        if (!clr_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            vld_r[i]   <= 1'b0;
            shift_r[i] <= 4'd0;
          end
        end else begin
          vld_r[0]   <= in_vld;
          shift_r[0] <= in_shift;
          for (int i = 1; i < DEPTH; i++) begin
            vld_r[i]   <= vld_r[i-1];
            shift_r[i] <= shift_r[i-1];
          end
        end
      end

      assign out_vld   = vld_r[DEPTH-1];
      assign out_shift = shift_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mul8_table_seq.sv
// Unsigned 8x8 multiplier built from four lookups into a shared 4x4 multiplication table.
// Issues nibble pairs on consecutive cycles, accumulates shifted results, returns via valid/ready.
module mul8_table_seq
  import mul_tbl_pkg::*;
#(
  parameter int TBL_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] in_x,
  input  logic [OPND_W-1:0] in_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_p,
  output logic [NIB_W-1:0]  tbl_a,
  output logic [NIB_W-1:0]  tbl_b,
  input  logic [TBL_W-1:0]  tbl_m,
  output logic              busy
);

  state_t            state_r, state_s;
  logic [1:0]        k_r, k_s;
  logic [OPND_W-1:0] x_r, y_r, x_src_s, y_src_s;
  logic [PROD_W-1:0] acc_r;
  logic              accept_s;
  logic              in_ready_r, out_valid_r, busy_r;
  logic [NIB_W-1:0]  tbl_a_r, tbl_b_r, tbl_a_s, tbl_b_s;
  logic              iss_vld_s, pipe_vld_s;
  logic [NIB_W-1:0]  iss_shift_s, pipe_shift_s;

  assign iss_vld_s   = (state_r == ISSUE);
  assign iss_shift_s = SHIFT[k_r];

  tbl_lat_pipe #(.DEPTH(TBL_LAT)) u_pipe (
    .clk       (clk),
    .clr_n     (rst_n),
    .in_vld    (iss_vld_s),
    .in_shift  (iss_shift_s),
    .out_vld   (pipe_vld_s),
    .out_shift (pipe_shift_s)
  );

  // Next-state, issue index and next table operands.
  always_comb begin
    state_s  = state_r;
    k_s      = k_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          state_s  = ISSUE;
          k_s      = 2'd0;
          accept_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (k_r == 2'd3) begin
          if (TBL_LAT > 0) begin
            state_s = DRAIN;
          end else begin
            state_s = DONE;
          end
        end else begin
          k_s = k_r + 2'd1;
        end
      end
      DRAIN: begin
        // Only the final issue carries shift 8, so its arrival ends the drain.
        if (pipe_vld_s && (pipe_shift_s == SHIFT[3])) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (accept_s) begin
      x_src_s = in_x;
      y_src_s = in_y;
    end else begin
      x_src_s = x_r;
      y_src_s = y_r;
    end

    if (state_s == ISSUE) begin
      tbl_a_s = nib_sel(x_src_s, X_HI[k_s]);
      tbl_b_s = nib_sel(y_src_s, Y_HI[k_s]);
    end else begin
      tbl_a_s = 4'd0;
      tbl_b_s = 4'd0;
    end
  end

  // State, operand latch, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      k_r         <= 2'd0;
      x_r         <= 8'd0;
      y_r         <= 8'd0;
      acc_r       <= 16'd0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      tbl_a_r     <= 4'd0;
      tbl_b_r     <= 4'd0;
    end else begin
      state_r     <= state_s;
      k_r         <= k_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s != IDLE);
      tbl_a_r     <= tbl_a_s;
      tbl_b_r     <= tbl_b_s;
      if (accept_s) begin
        x_r   <= in_x;
        y_r   <= in_y;
        acc_r <= 16'd0;
      end else if (pipe_vld_s) begin
        acc_r <= acc_r + ({8'd0, tbl_m} << pipe_shift_s);
      end else begin
        acc_r <= acc_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_p     = acc_r;
  assign tbl_a     = tbl_a_r;
  assign tbl_b     = tbl_b_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mul8_table_seq.sv
// Self-checking bench for mul8_table_seq: a latency-matched table model plus an
// arithmetic reference (x*y), directed corner cases and a randomized stream with stalls.
module tb_mul8_table_seq;

  localparam int TBL_LAT = 1;
  localparam int LAT     = 5 + TBL_LAT;
  localparam int TI      = (TBL_LAT == 0) ? 0 : TBL_LAT - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x, in_y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
  logic [3:0]  tbl_a, tbl_b;
  logic [7:0]  tbl_m;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  mul8_table_seq #(.TBL_LAT(TBL_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .tbl_a     (tbl_a),
    .tbl_b     (tbl_b),
    .tbl_m     (tbl_m),
    .busy      (busy)
  );

  // Table memory model: product of the operands, delayed TBL_LAT cycles.
  logic [7:0] prod4;
  logic [7:0] tpipe [4];
  assign prod4 = {4'd0, tbl_a} * {4'd0, tbl_b};
  always @(posedge clk) begin
    tpipe[0] <= prod4;
    for (int i = 1; i < 4; i++) tpipe[i] <= tpipe[i-1];
    cyc <= cyc + 1;
  end
  assign tbl_m = (TBL_LAT == 0) ? prod4 : tpipe[TI];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full request/response; returns the cycle of the accepting edge.
  task automatic do_txn(input logic [7:0] x, input logic [7:0] y, input int stall,
                        output int acc_cyc);
    logic [15:0] exp_p;
    int n;
    exp_p = {8'd0, x} * {8'd0, y};
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check_val("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_x      = x;
    in_y      = y;
    out_ready = (stall == 0);
    step();
    acc_cyc  = cyc;
    in_valid = 1'b0;
    in_x     = 8'($urandom);
    in_y     = 8'($urandom);
    n = 1;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check_val("latency", 32'(n), 32'(LAT));
    check_val("product", 32'(out_p), 32'(exp_p));
    check_val("busy_done", 32'(busy), 32'd1);
    for (int s = 0; s < stall; s++) begin
      step();
      check_val("stall_valid", 32'(out_valid), 32'd1);
      check_val("stall_hold", 32'(out_p), 32'(exp_p));
      check_val("stall_rdy", 32'(in_ready), 32'd0);
      check_val("stall_tbl", 32'({tbl_a, tbl_b}), 32'd0);
    end
    out_ready = 1'b1;
    step();
    check_val("pulse_end", 32'(out_valid), 32'd0);
    check_val("rdy_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c2;
    logic [7:0] rx, ry;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = 8'd0;
    in_y      = 8'd0;
    out_ready = 1'b1;
    repeat (3) step();
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_p", 32'(out_p), 32'd0);
    check_val("rst_tbl", 32'({tbl_a, tbl_b}), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();
    check_val("rel_in_ready", 32'(in_ready), 32'd1);
    check_val("rel_busy", 32'(busy), 32'd0);

    // Directed products, back to back to confirm throughput.
    do_txn(8'h12, 8'h34, 0, c0);
    do_txn(8'hFF, 8'hFF, 0, c1);
    do_txn(8'h00, 8'hAB, 0, c2);
    check_val("throughput1", 32'(c1 - c0), 32'(6 + TBL_LAT));
    check_val("throughput2", 32'(c2 - c1), 32'(6 + TBL_LAT));
    do_txn(8'hA5, 8'h3C, 5, c0);

    // Abort mid-transaction with reset, then confirm a clean follow-up.
    in_valid = 1'b1;
    in_x     = 8'h5A;
    in_y     = 8'hC3;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    check_val("abort_valid", 32'(out_valid), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_tbl", 32'({tbl_a, tbl_b}), 32'd0);
    check_val("abort_rdy", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    step();
    check_val("abort_rel_rdy", 32'(in_ready), 32'd1);
    do_txn(8'h07, 8'h09, 0, c0);

    // Randomized stream with random consumer stalls and edge-value operands.
    for (int t = 0; t < 800; t++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      if ($urandom_range(0, 7) == 0) rx = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      if ($urandom_range(0, 7) == 0) ry = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      do_txn(rx, ry, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0, c0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul8_table_seq.md
Name: mul8_table_seq

Overview:
Sequencer that builds an unsigned 8x8 -> 16-bit product from the shared 4x4 -> 8-bit multiplication table.
- Splits each operand into nibbles and issues the four nibble-pair lookups to the table on consecutive cycles.
- Shifts and accumulates the partial products, then returns the result over a valid/ready handshake.
- Sits between a requesting datapath and the table memory; owns the table's a/b inputs exclusively.

Parameters:
TBL_LAT, 1, cycles from tbl_a/tbl_b driven to the matching tbl_m being valid; legal range 0..3 (0 = combinational table).

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  request present
in_ready  output  1  block can accept a request
in_x  input  8  multiplicand, unsigned
in_y  input  8  multiplier, unsigned
out_valid  output  1  product available
out_ready  input  1  consumer takes product
out_p  output  16  product in_x*in_y
tbl_a  output  4  table operand a
tbl_b  output  4  table operand b
tbl_m  input  8  table result a*b
busy  output  1  high in any state other than IDLE

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Reset values: in_ready=0 while rst_n=0, then 1 on the first cycle after release. out_valid=0, out_p=0, tbl_a=0, tbl_b=0, busy=0. Accumulator, counters and lookup pipeline are cleared.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: in_ready=1. If in_valid is high at an edge, latch in_x/in_y and clear acc. This edge is cycle 0. Next state is ISSUE.
- ISSUE (cycles 1..4): issue index k=0..3 drives tbl_a/tbl_b to one nibble pair, with the listed shift:
  - k0: (x[3:0], y[3:0]), shift 0
  - k1: (x[3:0], y[7:4]), shift 4
  - k2: (x[7:4], y[3:0]), shift 4
  - k3: (x[7:4], y[7:4]), shift 8
  - After k3, go to DRAIN if TBL_LAT>0; otherwise go to DONE.
- Lookup pipeline: a TBL_LAT-deep delay line of {valid, shift}.
  - The result for issue k is sampled from tbl_m at cycle 1+k+TBL_LAT.
  - On that edge: acc <= acc + (tbl_m << shift). acc is 16 bits; the sum never exceeds 0xFE01, so it cannot overflow.
- DRAIN: wait until the last pipeline valid has accumulated, then go to DONE.
- DONE: out_valid=1 and out_p=acc, first asserted in cycle 5+TBL_LAT.
  - out_p is held stable and in_ready=0 while out_ready=0.
  - On out_valid&&out_ready, go to IDLE. in_ready rises the next cycle; it is never combinationally tied to out_ready.
- tbl_a/tbl_b are 0 outside ISSUE.
- Throughput: one product per 6+TBL_LAT cycles with out_ready held high.
- in_valid is ignored outside IDLE; the requester must hold in_x/in_y until accepted.
- Reset mid-operation: the transaction is abandoned and in-flight table results are discarded (pipeline valids cleared). No out_valid is produced for it.
- in_x=0 or in_y=0 still runs the full sequence. No early-out, so latency is constant.

Decomposition:
- Package mul_tbl_pkg holds:
  - state enum type: IDLE/ISSUE/DRAIN/DONE
  - NIB_W=4, TBL_W=8, OPND_W=8, PROD_W=16
  - constant arrays of nibble-select and shift per issue index 0..3
- One sub-module, tbl_lat_pipe: parameterised delay line carrying {valid, shift[3:0]}, depth TBL_LAT (pass-through when 0), with synchronous active-low clear.

Test Plan:
- TBL_LAT=1, accept x=0x12, y=0x34 at cycle 0, out_ready=1 -> out_valid in cycle 6 with out_p=0x03A8, single-cycle pulse, then in_ready=1 in cycle 7.
- x=0xFF, y=0xFF -> out_p=0xFE01. x=0x00, y=0xAB -> out_p=0x0000 with the same 6-cycle latency.
- out_ready held low 5 cycles after out_valid with x=0xA5, y=0x3C -> out_p=0x26AC stable throughout, in_ready=0, tbl_a/tbl_b=0.
- rst_n pulsed low in cycle 3 of a transaction -> next cycle out_valid=0, busy=0, tbl_a=0. After release, a new request 0x07*0x09 returns 0x003F with no residue from the aborted one.
- Rebuild with TBL_LAT=0 and TBL_LAT=2, using a matching table model -> first out_valid in cycle 5 and cycle 7 respectively, correct products.
- Exhaustive: all 65536 (x,y) pairs back-to-back with random out_ready stalls, checked against a reference model x*y -> zero mismatches, no lost or duplicated responses.
